// File: rtl/fp_normalize_round_pipe.sv
// Two-stage normalise (S1) and round/pack (S2) back end for the FP adder.
// Valid/ready handshake; in_ready is a combinational function of downstream ready.
module fp_normalize_round_pipe #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23,
    parameter int unsigned GRS_W  = 8,
    localparam int unsigned WORK_W = MANT_W + 1 + GRS_W,
    localparam int unsigned WORD_W = 1 + EXP_W + MANT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_special,
    input  logic [WORD_W-1:0] in_special_word,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_carry,
    input  logic [WORK_W-1:0] in_mant,
    input  logic [1:0]        in_rmode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [2:0]        out_flags
);

    localparam int unsigned XW = EXP_W + 2;
    localparam logic [XW-1:0] EXP_SAT = {2'b00, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {
        RmRne = 2'b00,
        RmRtz = 2'b01,
        RmRup = 2'b10,
        RmRdn = 2'b11
    } rmode_e;

    // Handshake
    logic w_s2_adv;
    logic w_in_ready;

    // S1 state
    logic              r1_valid;
    logic              r1_special;
    logic [WORD_W-1:0] r1_word;
    logic              r1_sign;
    logic [XW-1:0]     r1_exp;
    logic [WORK_W-1:0] r1_mant;
    logic              r1_sticky;
    rmode_e            r1_rmode;

    // S2 state
    logic              r2_valid;
    logic [WORD_W-1:0] r2_word;
    logic [2:0]        r2_flags;

    // S1 combinational
    logic [XW-1:0]     w_exp_in;
    logic [XW-1:0]     w_lz;
    logic [XW-1:0]     w_sh_lim;
    logic [XW-1:0]     w_sh;
    logic [XW-1:0]     w_n_exp;
    logic [WORK_W-1:0] w_n_mant;
    logic              w_n_sticky;
    logic              w_n_sign;

    // S2 combinational
    logic [MANT_W:0]   w_kept;
    logic              w_g;
    logic              w_s;
    logic              w_inc;
    logic [MANT_W+1:0] w_sum;
    logic [MANT_W-1:0] w_frac;
    logic [XW-1:0]     w_f_exp;
    logic              w_inx;
    logic              w_ovf;
    logic              w_use_inf;
    logic [WORD_W-1:0] w_r_word;
    logic [2:0]        w_r_flags;

    assign w_s2_adv   = !r2_valid || out_ready;
    assign w_in_ready = !r1_valid || w_s2_adv;
    assign in_ready   = w_in_ready;
    assign out_valid  = r2_valid;
    assign out_word   = r2_word;
    assign out_flags  = r2_flags;

    always_comb begin
        w_exp_in = {2'b00, in_exp};
        w_lz     = XW'(WORK_W);
        for (int i = 0; i < int'(WORK_W); i++) begin
            if (in_mant[i]) begin
                w_lz = XW'(int'(WORK_W) - 1 - i);
            end
        end
        // Left shift may not push the exponent below 1; what remains is subnormal.
        w_sh_lim   = (in_exp == '0) ? '0 : w_exp_in - XW'(1);
        w_sh       = (w_lz < w_sh_lim) ? w_lz : w_sh_lim;
        w_n_sign   = in_sign;
        w_n_sticky = 1'b0;
        w_n_mant   = in_mant << w_sh;
        w_n_exp    = '0;
        if (in_carry) begin
            w_n_mant   = {1'b1, in_mant[WORK_W-1:1]};
            w_n_sticky = in_mant[0];
            w_n_exp    = w_exp_in + XW'(1);
        end else if (in_mant == '0) begin
            w_n_mant = '0;
            w_n_sign = (rmode_e'(in_rmode) == RmRdn);
        end else begin
            w_n_exp = w_n_mant[WORK_W-1] ? w_exp_in - w_sh : '0;
        end
    end

    always_comb begin
        w_kept = r1_mant[WORK_W-1:GRS_W];
        w_g    = r1_mant[GRS_W-1];
        w_s    = (|r1_mant[GRS_W-2:0]) | r1_sticky;
        w_inc  = 1'b0;
        unique case (r1_rmode)
            RmRne: w_inc = w_g && (w_s || w_kept[0]);
            RmRtz: w_inc = 1'b0;
            RmRup: w_inc = (w_g || w_s) && !r1_sign;
            RmRdn: w_inc = (w_g || w_s) && r1_sign;
            default: w_inc = 1'b0;
        endcase
        w_sum = {1'b0, w_kept} + (MANT_W+2)'(w_inc);
        if (w_sum[MANT_W+1]) begin
            w_frac  = w_sum[MANT_W:1];
            w_f_exp = r1_exp + XW'(1);
        end else begin
            w_frac  = w_sum[MANT_W-1:0];
            // Subnormal rounded up into the hidden bit becomes the smallest normal.
            w_f_exp = (r1_exp == '0 && w_sum[MANT_W]) ? XW'(1) : r1_exp;
        end
        w_inx     = w_g || w_s;
        w_ovf     = (w_f_exp >= EXP_SAT);
        w_use_inf = (r1_rmode == RmRne) || (r1_rmode == RmRup && !r1_sign) ||
                    (r1_rmode == RmRdn && r1_sign);
        w_r_word  = {r1_sign, w_f_exp[EXP_W-1:0], w_frac};
        w_r_flags = {1'b0, (w_f_exp == '0) && w_inx, w_inx};
        if (w_ovf) begin
            w_r_word  = w_use_inf ? {r1_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}}
                                  : {r1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
            w_r_flags = 3'b101;
        end
        if (r1_special) begin
            w_r_word  = r1_word;
            w_r_flags = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r2_word  <= '0;
            r2_flags <= '0;
        end else begin
            if (w_in_ready) begin
                r1_valid <= in_valid;
            end
            if (w_s2_adv) begin
                r2_valid <= r1_valid;
            end
            if (w_s2_adv && r1_valid) begin
                r2_word  <= w_r_word;
                r2_flags <= w_r_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && w_in_ready) begin
            r1_special <= in_special;
            r1_word    <= in_special_word;
            r1_sign    <= w_n_sign;
            r1_exp     <= w_n_exp;
            r1_mant    <= w_n_mant;
            r1_sticky  <= w_n_sticky;
            r1_rmode   <= rmode_e'(in_rmode);
        end
    end

endmodule

// File: tb/tb_fp_normalize_round_pipe.sv
// Directed bench for fp_normalize_round_pipe: rounding vectors, backpressure, specials, reset flush.
module tb_fp_normalize_round_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_special = 1'b0;
    logic [31:0] in_special_word = '0;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic        in_carry = 1'b0;
    logic [31:0] in_mant = '0;
    logic [1:0]  in_rmode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [2:0]  out_flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_normalize_round_pipe dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_special      (in_special),
        .in_special_word (in_special_word),
        .in_sign         (in_sign),
        .in_exp          (in_exp),
        .in_carry        (in_carry),
        .in_mant         (in_mant),
        .in_rmode        (in_rmode),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_word        (out_word),
        .out_flags       (out_flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push one item through an idle pipe and check latency, word and flags.
    task automatic run_vec(input string tag, input logic sp, input logic [31:0] spw,
                           input logic sg, input logic cy, input logic [7:0] ex,
                           input logic [31:0] mt, input logic [1:0] rm,
                           input logic [31:0] ew, input logic [2:0] ef);
        in_special      = sp;
        in_special_word = spw;
        in_sign         = sg;
        in_carry        = cy;
        in_exp          = ex;
        in_mant         = mt;
        in_rmode        = rm;
        in_valid        = 1'b1;
        out_ready       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_word"}, out_word, ew);
        check({tag, "_flags"}, out_flags, ef);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_word", out_word, 0);
        check("rst_flags", out_flags, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_valid_after", out_valid, 0);

        // tag, special, sword, sign, carry, exp, mant, rmode, expected word, flags
        run_vec("carry_rne",  0, 32'h0, 0, 1, 8'd127, 32'h00000000, 2'b00, 32'h40000000, 3'b000);
        run_vec("cancel",     0, 32'h0, 0, 0, 8'd127, 32'h00800000, 2'b00, 32'h3B800000, 3'b000);
        run_vec("subnorm",    0, 32'h0, 0, 0, 8'd5,   32'h00800000, 2'b00, 32'h00080000, 3'b000);
        run_vec("tie_even",   0, 32'h0, 0, 0, 8'd127, 32'h80000080, 2'b00, 32'h3F800000, 3'b001);
        run_vec("tie_odd",    0, 32'h0, 0, 0, 8'd127, 32'h80000180, 2'b00, 32'h3F800002, 3'b001);
        run_vec("tie_rtz",    0, 32'h0, 0, 0, 8'd127, 32'h80000180, 2'b01, 32'h3F800001, 3'b001);
        run_vec("carry_stk",  0, 32'h0, 0, 1, 8'd127, 32'h00000101, 2'b00, 32'h40000001, 3'b001);
        run_vec("ovf_rne",    0, 32'h0, 0, 1, 8'd254, 32'hFFFFFFFF, 2'b00, 32'h7F800000, 3'b101);
        run_vec("ovf_rtz",    0, 32'h0, 0, 1, 8'd254, 32'hFFFFFFFF, 2'b01, 32'h7F7FFFFF, 3'b101);
        run_vec("ovf_rup_n",  0, 32'h0, 1, 1, 8'd254, 32'hFFFFFFFF, 2'b10, 32'hFF7FFFFF, 3'b101);
        run_vec("rup_pos",    0, 32'h0, 0, 0, 8'd127, 32'h80000001, 2'b10, 32'h3F800001, 3'b001);
        run_vec("rdn_neg",    0, 32'h0, 1, 0, 8'd127, 32'h80000001, 2'b11, 32'hBF800001, 3'b001);
        run_vec("underflow",  0, 32'h0, 0, 0, 8'd1,   32'h00000180, 2'b00, 32'h00000002, 3'b011);
        run_vec("sub_to_nrm", 0, 32'h0, 0, 0, 8'd1,   32'h7FFFFF80, 2'b00, 32'h00800000, 3'b001);
        run_vec("zero_rdn",   0, 32'h0, 0, 0, 8'd127, 32'h00000000, 2'b11, 32'h80000000, 3'b000);
        run_vec("zero_rne",   0, 32'h0, 1, 0, 8'd127, 32'h00000000, 2'b00, 32'h00000000, 3'b000);
        run_vec("special",    1, 32'h7FC00000, 0, 1, 8'd254, 32'hFFFFFFFF, 2'b00,
                32'h7FC00000, 3'b000);

        // Backpressure: four items A..D, downstream stalls three cycles after A appears.
        in_special = 1'b0;
        in_sign    = 1'b0;
        in_carry   = 1'b1;
        in_mant    = '0;
        in_rmode   = 2'b00;
        in_exp     = 8'd127;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        check("bp_c1_valid", out_valid, 0);
        in_exp = 8'd128;
        @(posedge clk);
        #1;
        check("bp_c2_valid", out_valid, 1);
        check("bp_c2_word", out_word, 32'h40000000);
        out_ready = 1'b0;
        in_exp    = 8'd129;
        #1;
        check("bp_c2_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("bp_c3_word", out_word, 32'h40000000);
        check("bp_c3_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("bp_c4_word", out_word, 32'h40000000);
        check("bp_c4_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("bp_c5_valid", out_valid, 1);
        check("bp_c5_word", out_word, 32'h40000000);
        out_ready = 1'b1;
        #1;
        check("bp_c5_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("bp_c6_word", out_word, 32'h40800000);
        in_exp = 8'd130;
        @(posedge clk);
        #1;
        check("bp_c7_word", out_word, 32'h41000000);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_c8_valid", out_valid, 1);
        check("bp_c8_word", out_word, 32'h41800000);
        @(posedge clk);
        #1;
        check("bp_c9_valid", out_valid, 0);

        // Reset with two items in flight, downstream never ready for them.
        out_ready = 1'b0;
        in_exp    = 8'd140;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_exp = 8'd141;
        @(posedge clk);
        #1;
        check("rf_full_valid", out_valid, 1);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rf_valid", out_valid, 0);
        check("rf_word", out_word, 0);
        check("rf_flags", out_flags, 0);
        check("rf_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("rf_no_output", out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
